// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: several producers share one FIFO write port, with
// bursts of up to MAX_BURST words per grant and registered FIFO wr/data.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int PTR_W     = 2,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  input  logic [CNT_W-1:0]          fifo_cnt,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [PTR_W-1:0]          owner,
  output logic                      busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]    owner_reg, owner_next;
  logic [BC_W-1:0]     burst_cnt_reg, burst_cnt_next;
  logic                fifo_wr_reg;
  logic [DATA_W-1:0]   fifo_data_reg;
  logic                busy_reg;
  logic                accept, space, found;
  logic [PTR_W-1:0]    sel, pick, idx;
  logic [DATA_W-1:0]   slice [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == N_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // fifo_cnt lags our own write by a cycle, so the in-flight write is added back in.
  assign space = ({1'b0, fifo_cnt} + {{CNT_W{1'b0}}, fifo_wr_reg}) < (CNT_W+1)'(DEPTH);

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_reg;
    idx   = rr_ptr_reg;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = ptr_inc(idx);
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    accept         = 1'b0;
    sel            = owner_reg;
    case (state_reg)
      IDLE: begin
        if (space && found) begin
          accept         = 1'b1;
          sel            = pick;
          owner_next     = pick;
          burst_cnt_next = BC_W'(1);
          if (MAX_BURST == 1) rr_ptr_next = ptr_inc(pick);
          else                state_next  = BURST;
        end
      end
      BURST: begin
        if (req[owner_reg] && (burst_cnt_reg < BC_W'(MAX_BURST))) begin
          if (space) begin
            accept         = 1'b1;
            burst_cnt_next = burst_cnt_reg + BC_W'(1);
          end
        end else begin
          rr_ptr_next    = ptr_inc(owner_reg);
          burst_cnt_next = '0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (accept && !rst) ack[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      fifo_wr_reg   <= 1'b0;
      fifo_data_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      fifo_wr_reg   <= accept;
      busy_reg      <= (state_next == BURST);
      if (accept) fifo_data_reg <= slice[sel];
    end
  end

  assign fifo_wr   = fifo_wr_reg;
  assign fifo_data = fifo_data_reg;
  assign owner     = owner_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: FIFO occupancy stand-in, behavioural arbitration model,
// a directed vector table, hand-written corner sequences and a random soak.
module tb_fifo_wr_arbiter;
  localparam int N_REQ = 4, PTR_W = 2, DATA_W = 8, DEPTH = 8, CNT_W = 4, MAX_BURST = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        ack;
  logic [CNT_W-1:0]        fifo_cnt = '0;
  logic                    fifo_wr;
  logic [DATA_W-1:0]       fifo_data;
  logic [PTR_W-1:0]        owner;
  logic                    busy;
  logic                    rd = 1'b0;

  int checks = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .N_REQ(N_REQ), .PTR_W(PTR_W), .DATA_W(DATA_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_cnt(fifo_cnt), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO occupancy as the real FIFO would report it
  always @(posedge clk) begin
    if (rst) fifo_cnt <= '0;
    else     fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(rd && (fifo_cnt != 0));
  end

  // Reference model state
  int           m_owner = -1;   // locked producer, -1 when none
  int           m_ptr = 0;
  int           m_taken = 0;
  int           m_last = 0;
  int           m_occ = 0;
  bit           m_pend = 1'b0;
  logic [7:0]   m_data = '0;
  logic [7:0]   word [N_REQ];
  int           last_k;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] ack;
    logic       wr;
    logic [7:0] data;
    logic [3:0] cnt;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT with the model, advance the model.
  task automatic cyc(input logic r, input logic [N_REQ-1:0] rq, input logic rdi);
    int k;
    bit sp;
    @(negedge clk);
    rst = r;
    req = rq;
    rd  = rdi;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = word[i];
    #1;
    k = -1;
    if (r) begin
      check("ack_in_rst", 32'(ack), 32'd0);
      m_owner = -1; m_ptr = 0; m_taken = 0; m_last = 0;
      m_occ = 0; m_pend = 1'b0; m_data = '0;
    end else begin
      check("fifo_wr", 32'(fifo_wr), 32'(m_pend));
      check("fifo_data", 32'(fifo_data), 32'(m_data));
      check("owner", 32'(owner), 32'(m_last));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("fifo_cnt", 32'(fifo_cnt), 32'(m_occ));
      sp = (m_occ + int'(m_pend)) < DEPTH;
      if (m_owner >= 0) begin
        if (rq[m_owner] && m_taken < MAX_BURST) begin
          if (sp) begin
            k = m_owner;
            m_taken++;
          end
        end else begin
          m_ptr = (m_owner + 1) % N_REQ;
          m_owner = -1;
          m_taken = 0;
        end
      end else if (sp) begin
        for (int j = 0; j < N_REQ; j++)
          if (k < 0 && rq[(m_ptr + j) % N_REQ]) k = (m_ptr + j) % N_REQ;
        if (k >= 0) begin
          m_last = k;
          m_taken = 1;
          if (MAX_BURST == 1) m_ptr = (k + 1) % N_REQ;
          else                m_owner = k;
        end
      end
      check("ack", 32'(ack), (k >= 0) ? (32'd1 << k) : 32'd0);
      m_occ = m_occ + int'(m_pend) - ((rdi && m_occ > 0) ? 1 : 0);
      m_pend = (k >= 0);
      if (k >= 0) begin
        m_data = word[k];
        $display("t=%0t accept req%0d data=%02h", $time, k, word[k]);
        word[k] = word[k] + 8'd1;
      end
    end
    last_k = k;
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
  endtask

  initial begin
    int acks, nb, idxa;
    bit prev;
    int bo[$];
    int bl[$];
    for (int i = 0; i < N_REQ; i++) word[i] = 8'(i * 16);

    // Reset with every producer requesting
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single producer burst, gap, second burst
    vt[0] = '{4'b0100, 4'b0100, 1'b0, 8'h00, 4'd0};
    vt[1] = '{4'b0100, 4'b0100, 1'b1, 8'hA0, 4'd0};
    vt[2] = '{4'b0100, 4'b0100, 1'b1, 8'hA1, 4'd1};
    vt[3] = '{4'b0100, 4'b0100, 1'b1, 8'hA2, 4'd2};
    vt[4] = '{4'b0100, 4'b0000, 1'b1, 8'hA3, 4'd3};
    vt[5] = '{4'b0100, 4'b0100, 1'b0, 8'hA3, 4'd4};
    vt[6] = '{4'b0100, 4'b0100, 1'b1, 8'hA4, 4'd4};
    vt[7] = '{4'b0000, 4'b0000, 1'b1, 8'hA5, 4'd5};
    vt[8] = '{4'b0000, 4'b0000, 1'b0, 8'hA5, 4'd6};
    do_reset();
    word[2] = 8'hA0;
    for (int v = 0; v < 9; v++) begin
      cyc(1'b0, vt[v].rq, 1'b0);
      check("vec_ack", 32'(ack), 32'(vt[v].ack));
      check("vec_wr", 32'(fifo_wr), 32'(vt[v].wr));
      check("vec_data", 32'(fifo_data), 32'(vt[v].data));
      check("vec_cnt", 32'(fifo_cnt), 32'(vt[v].cnt));
    end

    // Round robin with all producers requesting and the FIFO drained each cycle
    do_reset();
    prev = 1'b0;
    for (int c = 0; c < 25; c++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      idxa = -1;
      for (int i = 0; i < N_REQ; i++) if (ack[i]) idxa = i;
      if (idxa >= 0) begin
        if (!prev) begin
          bo.push_back(idxa);
          bl.push_back(1);
        end else begin
          bl[bl.size()-1] = bl[bl.size()-1] + 1;
        end
      end
      prev = (idxa >= 0);
    end
    nb = bo.size();
    check("rr_burst_count", 32'(nb), 32'd5);
    for (int b = 0; b < 5 && b < nb; b++) begin
      check("rr_owner", 32'(bo[b]), 32'(b % N_REQ));
      check("rr_len", 32'(bl[b]), 32'd4);
    end

    // Full FIFO, then a single read frees exactly one slot
    do_reset();
    acks = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(1'b0, 4'b0001, 1'b0);
      if (ack != 0) acks++;
    end
    check("full_acks", 32'(acks), 32'd8);
    check("full_cnt", 32'(fifo_cnt), 32'd8);
    cyc(1'b0, 4'b0001, 1'b1);
    check("full_rd_cycle_ack", 32'(ack), 32'd0);
    cyc(1'b0, 4'b0001, 1'b0);
    check("full_resume_ack", 32'(ack), 32'b0001);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 4'b0001, 1'b0);
      if (ack != 0) acks++;
    end
    check("full_after_acks", 32'(acks), 32'd0);

    // Owner drops request mid-burst
    do_reset();
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b1000, 1'b0);
    check("drop_gap_ack", 32'(ack), 32'd0);
    cyc(1'b0, 4'b1000, 1'b0);
    check("drop_next_grant", 32'(ack), 32'b1000);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 4'b1000, 1'b1);
      if (ack[2]) acks++;
    end
    check("drop_no_ack2", 32'(acks), 32'd0);

    // Reset in the middle of a burst
    do_reset();
    cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    check("mid_owner", 32'(owner), 32'd1);
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0011, 1'b0);
    check("mid_rst_wr", 32'(fifo_wr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grant", 32'(ack), 32'b0001);

    // Random soak with varying drain rate and occasional reset
    do_reset();
    for (int c = 0; c < 700; c++) begin
      logic [3:0] rq;
      logic       r, rdi;
      for (int i = 0; i < N_REQ; i++) rq[i] = ($urandom_range(3) != 0);
      rdi = ($urandom_range(3) < ((c / 100) % 4));
      r   = ($urandom_range(149) == 0);
      cyc(r, rq, rdi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
